// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the MIPS multicycle instruction-fetch stage.
package mips_fetch_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StDone
  } fetch_state_t;

  // Instruction field positions (MIPS R/I formats)
  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 26;
  localparam int unsigned RS_MSB     = 25;
  localparam int unsigned RS_LSB     = 21;
  localparam int unsigned RT_MSB     = 20;
  localparam int unsigned RT_LSB     = 16;
  localparam int unsigned RD_MSB     = 15;
  localparam int unsigned RD_LSB     = 11;
  localparam int unsigned SHAMT_MSB  = 10;
  localparam int unsigned SHAMT_LSB  = 6;
  localparam int unsigned FUNCT_MSB  = 5;
  localparam int unsigned FUNCT_LSB  = 0;
  localparam int unsigned IMM_MSB    = 15;
  localparam int unsigned IMM_LSB    = 0;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;
  localparam int unsigned PC_STEP          = 4;

endpackage

// File: rtl/instr_fetch.sv
// Multicycle MIPS instruction fetch: owns PC and IR, handshakes with instruction
// memory and exposes the decoded instruction fields.
// Optional feature: define FETCH_TIMEOUT_EN to abort a fetch that receives no
// mem_ack within TIMEOUT_CYCLES REQ cycles and raise a sticky fetch_err.
module instr_fetch
  import mips_fetch_pkg::*;
#(
  parameter int unsigned          BIT_WIDTH      = 32,
  parameter int unsigned          HALF_BIT_WIDTH = 16,
  parameter logic [BIT_WIDTH-1:0] RESET_PC       = BIT_WIDTH'(DEFAULT_RESET_PC),
  parameter int unsigned          TIMEOUT_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      fetch_start,
  input  logic                      pc_load,
  input  logic [BIT_WIDTH-1:0]      pc_next,
  output logic                      mem_req,
  output logic [BIT_WIDTH-1:0]      mem_addr,
  input  logic [BIT_WIDTH-1:0]      mem_rdata,
  input  logic                      mem_ack,
  output logic [BIT_WIDTH-1:0]      ir,
  output logic [5:0]                opcode,
  output logic [4:0]                rs,
  output logic [4:0]                rt,
  output logic [4:0]                rd,
  output logic [4:0]                shamt,
  output logic [5:0]                funct,
  output logic [HALF_BIT_WIDTH-1:0] imm,
  output logic [BIT_WIDTH-1:0]      pc,
  output logic [BIT_WIDTH-1:0]      pc_plus4,
  output logic                      instr_valid,
  output logic                      busy,
  output logic                      fetch_err
);

  fetch_state_t         state_q, state_d;
  logic [BIT_WIDTH-1:0] pc_q, pc_d;
  logic [BIT_WIDTH-1:0] ir_q, ir_d;
  logic                 timeout_hit;

  assign pc_plus4 = pc_q + BIT_WIDTH'(PC_STEP);

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  // Last permitted REQ cycle passed without an ack; a same-cycle ack wins.
  assign timeout_hit = (state_q == StReq) && !mem_ack &&
                       (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // REQ wait counter: held at zero outside REQ so it is clear on entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (state_q != StReq) begin
      cnt_q <= '0;
    end else if (!mem_ack && !timeout_hit) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Sticky timeout flag, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (timeout_hit) begin
      err_q <= 1'b1;
    end
  end

  assign fetch_err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign fetch_err   = 1'b0;
`endif

  // State, PC and IR registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Next-state logic; PC/IR move only on pc_load in idle or an ack in REQ
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    unique case (state_q)
      StIdle: begin
        if (pc_load) begin
          pc_d = {pc_next[BIT_WIDTH-1:2], 2'b00};
        end else if (fetch_start) begin
          state_d = StReq;
        end
      end
      StReq: begin
        if (mem_ack) begin
          ir_d    = mem_rdata;
          pc_d    = pc_plus4;
          state_d = StDone;
        end else if (timeout_hit) begin
          state_d = StIdle;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign mem_req     = (state_q == StReq);
  assign instr_valid = (state_q == StDone);
  assign busy        = (state_q != StIdle);
  assign mem_addr    = pc_q;
  assign pc          = pc_q;
  assign ir          = ir_q;

  assign opcode = ir_q[OPCODE_MSB:OPCODE_LSB];
  assign rs     = ir_q[RS_MSB:RS_LSB];
  assign rt     = ir_q[RT_MSB:RT_LSB];
  assign rd     = ir_q[RD_MSB:RD_LSB];
  assign shamt  = ir_q[SHAMT_MSB:SHAMT_LSB];
  assign funct  = ir_q[FUNCT_MSB:FUNCT_LSB];
  assign imm    = ir_q[IMM_MSB:IMM_LSB];

endmodule
